// File: rtl/norm_row_replay.sv
// norm_row_replay
// Ping-pong row buffer in front of the normalisation engines. Collects a BF16
// stream (upper half of 32-bit words) into rows of ROW_LEN elements and replays
// each stored row 1..MAX_PASS times with backpressure on both sides. One bank
// loads while the other replays.
//
// Optional feature: define ROW_REPLAY_LEN_CHK_EN to check s_tlast against the
// element count and raise the sticky err_len flag. Without it s_tlast is
// ignored and err_len is tied low.
//
// Reader FSM
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_IDLE     | no row to replay; waits for the read bank to become FULL
//   ST_PREFETCH | issues the address-0 read of a newly FULL bank
//   ST_STREAM   | issues one read per output slot, across passes of the row
//
// The bank RAM read register doubles as the output data register, so a read is
// only issued when the output slot is empty or being accepted. That keeps
// m_tdata stable under backpressure and gives one element per cycle when
// m_tready stays high.
module norm_row_replay #(
  parameter int DATA_W   = 16,
  parameter int ROW_LEN  = 768,
  parameter int ADDR_W   = 10,
  parameter int MAX_PASS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pass_cnt,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic [31:0] s_tdata,
  input  logic        s_tlast,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [31:0] m_tdata,
  output logic        m_tlast,
  output logic [1:0]  m_tpass,
  output logic        m_tfinal,
  output logic        err_len
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROW_LEN - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREFETCH = 2'd1;
  localparam logic [1:0] ST_STREAM   = 2'd2;

  // Stored replay count: 0 means a single pass, anything above MAX_PASS saturates.
  function automatic logic [1:0] clamp_pass(input logic [1:0] p);
    if (p == 2'd0)
      return 2'd1;
    else if (int'(p) > MAX_PASS)
      return 2'(MAX_PASS);
    else
      return p;
  endfunction

  // Bank status
  logic [1:0]       bank_full;
  logic [1:0][1:0]  bank_pass;

  // Writer side
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_cnt;
  logic [1:0]        wr_pass;
  logic              s_hs;
  logic              wr_wrap;
  logic [1:0]        row_pass;

  // Reader side
  logic [1:0]        rd_state;
  logic              rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_pass;
  logic [1:0]        rd_npass;
  logic              rd_final;
  logic              rd_load;
  logic              rd_issue;
  logic              rd_free;
  logic              rd_next_ready;

  // Output slot
  logic              out_valid;
  logic              out_bank;
  logic              out_last;
  logic [1:0]        out_pass;
  logic              out_final;

  assign s_tready = ~bank_full[wr_bank];
  assign s_hs     = s_tvalid && s_tready;
  assign wr_wrap  = s_hs && (wr_cnt == LAST_ADDR);
  // The pass count belongs to the row's first element; a one-element row uses it directly.
  assign row_pass = (wr_cnt == '0) ? clamp_pass(pass_cnt) : wr_pass;

  assign rd_npass = bank_pass[rd_bank];
  assign rd_final = (rd_pass == (rd_npass - 2'd1));
  assign rd_load  = ~out_valid || m_tready;
  assign rd_issue = rd_load && ((rd_state == ST_PREFETCH) || (rd_state == ST_STREAM));
  assign rd_free  = rd_issue && (rd_addr == LAST_ADDR) && rd_final;
  // The other bank counts as ready if it is FULL or completes this very cycle,
  // so back-to-back rows hand over without a bubble.
  assign rd_next_ready = bank_full[~rd_bank] || (wr_wrap && (wr_bank != rd_bank));

  // Writer: element counter, bank toggle and first-element pass capture
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
      wr_pass <= 2'd1;
    end else if (s_hs) begin
      if (wr_cnt == '0)
        wr_pass <= clamp_pass(pass_cnt);
      if (wr_wrap) begin
        wr_cnt  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_cnt <= wr_cnt + ADDR_W'(1);
      end
    end
  end

  // Bank FULL flags: set by the writer on wrap, cleared by the reader after the last read
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full <= '0;
      bank_pass <= '0;
    end else begin
      if (wr_wrap) begin
        bank_full[wr_bank] <= 1'b1;
        bank_pass[wr_bank] <= row_pass;
      end
      if (rd_free)
        bank_full[rd_bank] <= 1'b0;
    end
  end

  // Bank memories: one write port and one registered read port each
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [DATA_W-1:0] mem [ROW_LEN];
    logic [DATA_W-1:0] q;

    // Write port
    always_ff @(posedge clk) begin
      if (s_hs && (wr_bank == 1'(b)))
        mem[wr_cnt] <= s_tdata[31 -: DATA_W];
    end

    // Read port; the register holds its word while the output is stalled
    always_ff @(posedge clk) begin
      if (rst)
        q <= '0;
      else if (rd_issue && (rd_bank == 1'(b)))
        q <= mem[rd_addr];
    end
  end

  // Reader FSM: issues reads into the output slot and walks addresses and passes
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state  <= ST_IDLE;
      rd_bank   <= 1'b0;
      rd_addr   <= '0;
      rd_pass   <= 2'd0;
      out_valid <= 1'b0;
      out_bank  <= 1'b0;
      out_last  <= 1'b0;
      out_pass  <= 2'd0;
      out_final <= 1'b0;
    end else begin
      case (rd_state)
        ST_IDLE: begin
          if (rd_load)
            out_valid <= 1'b0;
          if (bank_full[rd_bank])
            rd_state <= ST_PREFETCH;
        end
        ST_PREFETCH, ST_STREAM: begin
          if (rd_load) begin
            out_valid <= 1'b1;
            out_bank  <= rd_bank;
            out_last  <= (rd_addr == LAST_ADDR);
            out_pass  <= rd_pass;
            out_final <= rd_final;
            if (rd_addr == LAST_ADDR) begin
              rd_addr <= '0;
              if (rd_final) begin
                rd_pass  <= 2'd0;
                rd_bank  <= ~rd_bank;
                rd_state <= rd_next_ready ? ST_PREFETCH : ST_IDLE;
              end else begin
                rd_pass  <= rd_pass + 2'd1;
                rd_state <= ST_STREAM;
              end
            end else begin
              rd_addr  <= rd_addr + ADDR_W'(1);
              rd_state <= ST_STREAM;
            end
          end
        end
        default: rd_state <= ST_IDLE;
      endcase
    end
  end

  assign m_tvalid = out_valid;
  assign m_tdata  = {(out_bank ? g_bank[1].q : g_bank[0].q), {(32 - DATA_W){1'b0}}};
  assign m_tlast  = out_last;
  assign m_tpass  = out_pass;
  assign m_tfinal = out_final;

`ifdef ROW_REPLAY_LEN_CHK_EN
  logic err_q;
  logic unused_bits;

  // Sticky length error: s_tlast must coincide exactly with the final count
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (s_hs && (s_tlast != (wr_cnt == LAST_ADDR)))
      err_q <= 1'b1;
  end

  assign err_len     = err_q;
  assign unused_bits = ^s_tdata[31-DATA_W:0];
`else
  logic unused_bits;

  assign err_len     = 1'b0;
  assign unused_bits = ^{s_tdata[31-DATA_W:0], s_tlast};
`endif

endmodule

// File: tb/tb_norm_row_replay.sv
// Scoreboard bench for norm_row_replay with ROW_LEN=8, MAX_PASS=3.
// Expected output elements are queued when a row has been driven and are
// popped as the DUT emits them.
module tb_norm_row_replay;

  localparam int ROW_LEN  = 8;
  localparam int MAX_PASS = 3;
`ifdef ROW_REPLAY_LEN_CHK_EN
  localparam logic [31:0] EXP_ERR = 32'd1;
`else
  localparam logic [31:0] EXP_ERR = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pass_cnt;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic [1:0]  m_tpass;
  logic        m_tfinal;
  logic        err_len;

  norm_row_replay #(
    .DATA_W(16), .ROW_LEN(ROW_LEN), .ADDR_W(3), .MAX_PASS(MAX_PASS)
  ) dut (
    .clk(clk), .rst(rst), .pass_cnt(pass_cnt),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .m_tpass(m_tpass), .m_tfinal(m_tfinal), .err_len(err_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
    logic [1:0]  p;
    logic        f;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  int   hs_count = 0;
  int   hs_first_cyc = 0;
  int   hs_last_cyc = 0;
  int   stall_cnt = 0;
  bit   seen_valid = 0;
  int   first_valid_cyc = 0;
  int   t_last_in = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int eff_pass(input int pc);
    if (pc == 0) return 1;
    if (pc > MAX_PASS) return MAX_PASS;
    return pc;
  endfunction

  task automatic push_row(input logic [15:0] base, input int pc);
    exp_t e;
    int np = eff_pass(pc);
    for (int p = 0; p < np; p++) begin
      for (int i = 0; i < ROW_LEN; i++) begin
        e.d = 16'(int'(base) + i);
        e.l = (i == ROW_LEN - 1);
        e.p = 2'(p);
        e.f = (p == np - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Drive one element and hold it until accepted; returns 1 ns after the transfer edge.
  task automatic send_elem(input logic [15:0] d, input logic last, input logic [1:0] pc);
    int n = 0;
    s_tvalid = 1'b1;
    s_tdata  = {d, 16'hA5A5};
    s_tlast  = last;
    pass_cnt = pc;
    do begin
      @(negedge clk);
      n++;
    end while (!s_tready && n < 300);
    chk("in_accept", s_tready, 1);
    @(posedge clk);
    #1;
    s_tvalid  = 1'b0;
    t_last_in = cyc;
  endtask

  task automatic send_row(input logic [15:0] base, input int pc);
    for (int i = 0; i < ROW_LEN; i++)
      send_elem(16'(int'(base) + i), (i == ROW_LEN - 1), 2'(pc));
    push_row(base, pc);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    hs_count   = 0;
    stall_cnt  = 0;
    seen_valid = 0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Output monitor: scoreboard pop on handshake, stability check while stalled
  initial begin
    exp_t e;
    bit stalled = 0;
    logic [31:0] held_data = '0;
    logic [3:0]  held_flags = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 0;
      end else begin
        if (stalled) begin
          chk("hold_valid", m_tvalid, 1);
          chk("hold_data", m_tdata, held_data);
          chk("hold_flags", {m_tlast, m_tpass, m_tfinal}, held_flags);
        end
        if (m_tvalid && !seen_valid) begin
          seen_valid = 1;
          first_valid_cyc = cyc;
        end
        if (m_tvalid && m_tready) begin
          chk("out_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_data", m_tdata, {e.d, 16'h0000});
            chk("out_flags", {m_tlast, m_tpass, m_tfinal}, {e.l, e.p, e.f});
          end
          hs_count++;
          if (hs_count == 1) hs_first_cyc = cyc;
          hs_last_cyc = cyc;
        end
        stalled = m_tvalid && !m_tready;
        if (stalled) begin
          stall_cnt++;
          held_data  = m_tdata;
          held_flags = {m_tlast, m_tpass, m_tfinal};
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    pass_cnt = 2'd0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", s_tready, 1);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_tpass", m_tpass, 0);
    chk("rst_m_tfinal", m_tfinal, 0);
    chk("rst_err_len", err_len, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Two-pass row, latency from last input to first output
    clr_counts();
    send_row(16'h3F80, 2);
    n = 0;
    while (!seen_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t1_latency", 32'(first_valid_cyc - t_last_in), 2);
    wait_drain();
    chk("t1_count", hs_count, 16);

    // Three rows against a stalled output, then release
    clr_counts();
    m_tready = 1'b0;
    send_row(16'h3F90, 1);
    send_row(16'h3FA0, 1);
    @(negedge clk);
    chk("t2_tready_low", s_tready, 0);
    chk("t2_prefetched", m_tvalid, 1);
    @(posedge clk);
    #1;
    fork
      send_row(16'h3FB0, 1);
      m_tready = 1'b1;
    join
    wait_drain();
    chk("t2_count", hs_count, 24);
    chk("t2_no_bubble", 32'(hs_last_cyc - hs_first_cyc), 23);

    // Pass count boundaries
    clr_counts();
    send_row(16'h3FC0, 0);
    wait_drain();
    chk("t3_pass0_count", hs_count, 8);
    clr_counts();
    send_row(16'h3FD0, 3);
    wait_drain();
    chk("t3_pass3_count", hs_count, 24);

    // Toggling backpressure during a three-pass row
    clr_counts();
    fork
      send_row(16'h3FE0, 3);
      begin
        repeat (80) begin
          @(posedge clk);
          #1;
          m_tready = ~m_tready;
        end
        m_tready = 1'b1;
      end
    join
    wait_drain();
    chk("t4_count", hs_count, 24);
    chk("t4_stalls_seen", 32'(stall_cnt >= 8), 1);

    // Reset while element 5 of a two-pass row is on the output
    clr_counts();
    m_tready = 1'b1;
    send_row(16'h3F00, 2);
    n = 0;
    while (hs_count < 4 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t5_reached_elem5", hs_count, 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    chk("t5_m_tvalid", m_tvalid, 0);
    chk("t5_s_tready", s_tready, 1);
    clr_counts();
    repeat (6) @(posedge clk);
    #1;
    chk("t5_no_old_data", hs_count, 0);
    send_row(16'h3F40, 2);
    wait_drain();
    chk("t5_next_row_count", hs_count, 16);

    // Misplaced s_tlast: on element 6, missing on element 8
    clr_counts();
    for (int i = 0; i < ROW_LEN; i++) begin
      send_elem(16'(16'h3F60 + i), (i == 5), 2'd1);
      if (i == 4) chk("t6_err_before", err_len, 0);
      if (i == 5) chk("t6_err_set", err_len, EXP_ERR);
    end
    push_row(16'h3F60, 1);
    chk("t6_err_held", err_len, EXP_ERR);
    wait_drain();
    chk("t6_grouping_count", hs_count, 8);
    chk("t6_err_still_held", err_len, EXP_ERR);
    pulse_rst();
    chk("t6_err_cleared", err_len, 0);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/norm_row_replay.md
# norm_row_replay

Parametrised ping-pong row buffer that sits in front of the normalisation engines (layernorm / rmsnorm). It accepts a BF16 element stream packed in the upper half of 32-bit words, groups it into rows of ROW_LEN elements, and replays each stored row 1..MAX_PASS times, once per statistics/apply pass. It adds AXI-stream-style backpressure on both sides, which the fixed single-pass norm front-end does not have. Two banks let row N+1 load while row N replays.

## Interface
- DATA_W, 16: element width; BF16 carried in s_tdata[31:32-DATA_W].
- ROW_LEN, 768: elements per row; 49152 elements = 64 rows.
- ADDR_W, 10: bank address width; ceil(log2(ROW_LEN)) ≤ ADDR_W.
- MAX_PASS, 3: maximum replays per row, 1..3.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- pass_cnt  in  2  replays for the row being loaded; sampled with that row's first accepted element.
- s_tvalid  in  1  input element valid.
- s_tready  out  1  input accept.
- s_tdata  in  32  {bf16, 16'b0}; bits [15:0] ignored.
- s_tlast  in  1  last element of row; checked only with ROW_REPLAY_LEN_CHK_EN.
- m_tvalid  out  1  output element valid.
- m_tready  in  1  downstream accept.
- m_tdata  out  32  {bf16, 16'b0}.
- m_tlast  out  1  last element of the current pass.
- m_tpass  out  2  current pass index, 0-based.
- m_tfinal  out  1  current pass is the row's last pass.
- err_len  out  1  sticky row-length error.

## Operation
- Handshake: a transfer occurs on a cycle with tvalid && tready. m_tvalid, once high, holds until accepted, and m_tdata, m_tlast, m_tpass and m_tfinal stay stable during that time.
- Writer: fills the write bank at addresses 0..ROW_LEN-1.
  - The element count wraps to 0 after ROW_LEN-1.
  - On that wrap the bank is marked FULL with its stored pass count and the writer switches banks.
  - s_tready = write bank not FULL.
- Pass count: stored value = max(1, min(pass_cnt, MAX_PASS)), so 0 becomes 1.
- Reader FSM:
  - IDLE: go to PREFETCH when the read bank is FULL.
  - PREFETCH: issue the address-0 read, then go to STREAM.
  - STREAM:
    - Address increments on each output handshake.
    - At the end of a pass that is not the last: address resets to 0 and m_tpass increments.
    - At the end of the last pass: the bank is freed, the reader switches banks and returns to IDLE. If the other bank is already FULL it goes to PREFETCH instead, without passing through IDLE.
- Bank memories: synchronous-read RAM, one write port and one read port per bank. The reader uses skid/prefetch so there are no bubbles while m_tready=1.
- Simultaneous events:
  - Freeing a bank and writing the other bank in the same cycle is legal.
  - A freed bank raises s_tready on the following cycle.
- Reset mid-operation:
  - Both banks EMPTY, all counters 0, FSM IDLE.
  - Stored data is discarded and never emitted.

## Timing
- Reset values: s_tready=1, m_tvalid=0, m_tdata=0, m_tlast=0, m_tpass=0, m_tfinal=0, err_len=0.
- Latency: the first element of a row is on m_tdata with m_tvalid=1 exactly 2 cycles after the handshake of that row's last input element, when the reader is IDLE.
- Throughput with m_tready held high and a row of P passes:
  - One element per cycle across pass boundaries and across back-to-back rows.
  - A row occupies the output for exactly P·ROW_LEN cycles.
- Input throughput: 1 element/cycle until both banks are FULL.
- m_tlast=1 on the output element at address ROW_LEN-1 of every pass. m_tfinal=1 on every element of the last pass.
- m_tready low: the output holds its state. The read address does not advance and the prefetched word is not lost.

## Configuration
- Macro: ROW_REPLAY_LEN_CHK_EN.
- Defined: err_len is set on either of these, and stays set until rst:
  - an accepted s_tlast=1 at a count other than ROW_LEN-1;
  - s_tlast=0 at count ROW_LEN-1.
  - Row grouping still follows the count only; no truncation or padding.
- Undefined: s_tlast is ignored and err_len is tied to 0.

## Test plan
Bench parameters: ROW_LEN=8, MAX_PASS=3.
- Reset, then 8 elements 0x3F80..0x3F87 with pass_cnt=2 and m_tready=1 → 16 outputs, 0x3F80..0x3F87 twice. First output 2 cycles after the last input. m_tlast on outputs 8 and 16. m_tpass=0 for the first 8 and 1 for the second 8. m_tfinal on outputs 9..16.
- 3 back-to-back rows, pass_cnt=1, m_tready=0 → s_tready drops after 16 accepted elements. Release m_tready → 24 outputs in order with no bubble between rows.
- pass_cnt=0 and pass_cnt=3 rows → 8 and 24 outputs respectively.
- Toggle m_tready every cycle during a 3-pass row → sequence intact, and each m_tdata held while m_tvalid && !m_tready.
- Assert rst at output element 5 of a 2-pass row → next cycle m_tvalid=0 and s_tready=1. The next row replays cleanly with none of the old data emitted.
- With ROW_REPLAY_LEN_CHK_EN defined, s_tlast on element 6 → err_len=1 the next cycle, held until rst. The 8-element grouping is unchanged.
